// File: rtl/neuron_mac.sv
// Single-neuron MAC: streams NUM_INPUTS signed samples against a local weight
// store, accumulates with saturation, adds bias and emits one sum per frame.
module neuron_mac #(
    parameter int DATA_WIDTH       = 16,
    parameter int WEIGHT_INT_WIDTH = 4,
    parameter int NUM_INPUTS       = 784,
    parameter int ADDR_WIDTH       = $clog2(NUM_INPUTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    w_wr_en,
    input  logic [ADDR_WIDTH-1:0]   w_wr_addr,
    input  logic [DATA_WIDTH-1:0]   w_wr_data,
    input  logic                    b_wr_en,
    input  logic [2*DATA_WIDTH-1:0] b_wr_data,
    output logic                    busy,
    output logic                    sum_valid,
    output logic [2*DATA_WIDTH-1:0] sum_out
);

    localparam int SW = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_INPUTS - 1);

    typedef logic signed [SW-1:0] sum_t;

    if (NUM_INPUTS < 2 || WEIGHT_INT_WIDTH > DATA_WIDTH - 1 ||
        (1 << ADDR_WIDTH) < NUM_INPUTS) begin : g_bad_param
        $error("neuron_mac: illegal parameter combination");
    end

    // Two's-complement add that clamps on overflow instead of wrapping.
    function automatic sum_t sat_add(input sum_t a, input sum_t b);
        sum_t r;
        r = a + b;
        if (!a[SW-1] && !b[SW-1] && r[SW-1])
            sat_add = {1'b0, {(SW-1){1'b1}}};
        else if (a[SW-1] && b[SW-1] && !r[SW-1])
            sat_add = {1'b1, {(SW-1){1'b0}}};
        else
            sat_add = r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]        in_cnt_q, in_cnt_d;

    logic                         s1_vld_q, s1_first_q, s1_last_q;
    logic signed [DATA_WIDTH-1:0] s1_data_q;
    logic signed [DATA_WIDTH-1:0] s1_w_q;

    logic                         s2_vld_q, s2_first_q, s2_last_q;
    sum_t                         s2_prod_q, s2_prod_d;

    logic                         s3_vld_q, s3_last_q;
    sum_t                         acc_q, acc_d;

    sum_t                         bias_q, bias_d;
    sum_t                         sum_q, sum_d;
    logic                         sum_vld_q, sum_vld_d;

    logic [DATA_WIDTH-1:0]        wmem_q [NUM_INPUTS];

    logic                         w_we;
    logic                         is_first, is_last;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    // Any stage holding a sample, or the output pulse itself, keeps the
    // configuration frozen so a frame never sees a half-updated weight set.
    assign busy = (in_cnt_q != '0) | s1_vld_q | s2_vld_q | s3_vld_q | sum_vld_q;

    assign w_we     = w_wr_en && !busy && (int'(w_wr_addr) < NUM_INPUTS);
    assign is_first = (in_cnt_q == '0);
    assign is_last  = (in_cnt_q == LAST_IDX);

    always_comb begin
        in_cnt_d = in_cnt_q;
        if (in_valid)
            in_cnt_d = is_last ? '0 : in_cnt_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Weight store: synchronous read, contents survive reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_we)
            wmem_q[w_wr_addr] <= w_wr_data;
    end

    always_ff @(posedge clk) begin
        if (in_valid)
            s1_w_q <= wmem_q[in_cnt_q];
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        s2_prod_d = sum_t'(s1_data_q) * sum_t'(s1_w_q);
    end

    // A first product overwrites acc, so frames need no separate clear and
    // back-to-back frames overlap cleanly with the S4 read of the old acc.
    always_comb begin
        acc_d = acc_q;
        if (s2_vld_q)
            acc_d = s2_first_q ? s2_prod_q : sat_add(acc_q, s2_prod_q);
    end

    always_comb begin
        sum_d     = sum_q;
        sum_vld_d = 1'b0;
        if (s3_vld_q && s3_last_q) begin
            sum_d     = sat_add(acc_q, bias_q);
            sum_vld_d = 1'b1;
        end
    end

    always_comb begin
        bias_d = bias_q;
        if (b_wr_en && !busy)
            bias_d = b_wr_data;
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            s3_vld_q   <= 1'b0;
            s3_last_q  <= 1'b0;
            acc_q      <= '0;
            bias_q     <= '0;
            sum_q      <= '0;
            sum_vld_q  <= 1'b0;
        end else begin
            in_cnt_q   <= in_cnt_d;

            s1_vld_q   <= in_valid;
            s1_first_q <= in_valid && is_first;
            s1_last_q  <= in_valid && is_last;
            if (in_valid)
                s1_data_q <= in_data;

            s2_vld_q   <= s1_vld_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            if (s1_vld_q)
                s2_prod_q <= s2_prod_d;

            s3_vld_q   <= s2_vld_q;
            s3_last_q  <= s2_vld_q && s2_last_q;
            acc_q      <= acc_d;

            bias_q     <= bias_d;
            sum_q      <= sum_d;
            sum_vld_q  <= sum_vld_d;
        end
    end

    assign sum_out   = sum_q;
    assign sum_valid = sum_vld_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed + randomized bench for neuron_mac with an arithmetic frame model
// and a scoreboard that checks both value and arrival cycle of every sum.
module tb_neuron_mac;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          w_wr_en = 1'b0;
    logic [AW-1:0] w_wr_addr = '0;
    logic [DW-1:0] w_wr_data = '0;
    logic          b_wr_en = 1'b0;
    logic [2*DW-1:0] b_wr_data = '0;
    logic          busy;
    logic          sum_valid;
    logic [2*DW-1:0] sum_out;

    neuron_mac #(.DATA_WIDTH(DW), .WEIGHT_INT_WIDTH(4), .NUM_INPUTS(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .b_wr_en(b_wr_en), .b_wr_data(b_wr_data),
        .busy(busy), .sum_valid(sum_valid), .sum_out(sum_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [31:0] val; int cyc; } exp_t;
    exp_t exp_q[$];

    logic signed [DW-1:0] m_w [N];
    logic signed [DW-1:0] m_x [N];
    longint m_bias = 0;
    int pos = 0;

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic logic [31:0] frame_sum();
        longint acc;
        acc = longint'(m_w[0]) * longint'(m_x[0]);
        for (int i = 1; i < N; i++)
            acc = sat32(acc + longint'(m_w[i]) * longint'(m_x[i]));
        return 32'(sat32(acc + m_bias));
    endfunction

    // Scoreboard: every pulse must be predicted, in order, on the right cycle.
    always @(negedge clk) begin
        if (rst_n && sum_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_pulse observed=%h expected=none", sum_out);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                assert (sum_out === e.val) else begin
                    failures++;
                    $error("FAIL sum_value observed=%h expected=%h", sum_out, e.val);
                end
                checks++;
                assert (cyc === e.cyc) else begin
                    failures++;
                    $error("FAIL sum_timing observed_cycle=%0d expected_cycle=%0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic samp(input logic [DW-1:0] x);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = x;
        m_x[pos] = x;
        if (pos == N - 1) begin
            exp_q.push_back('{frame_sum(), cyc + 4});
            pos = 0;
        end else begin
            pos++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wr(input bit we, input int addr, input logic [DW-1:0] wd,
                      input bit be, input logic [2*DW-1:0] bd, input bit accept);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        assert (busy === !accept) else begin
            failures++;
            $error("FAIL wr_busy observed=%b expected=%b", busy, !accept);
        end
        w_wr_en = we; w_wr_addr = AW'(addr); w_wr_data = wd;
        b_wr_en = be; b_wr_data = bd;
        @(posedge clk); #1;
        w_wr_en = 1'b0; b_wr_en = 1'b0;
        if (accept && we) m_w[addr] = wd;
        if (accept && be) m_bias = longint'($signed(bd));
    endtask

    task automatic set_all_w(input logic [DW-1:0] w);
        for (int i = 0; i < N; i++) wr(1'b1, i, w, 1'b0, '0, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        assert (busy === 1'b0) else begin
            failures++;
            $error("FAIL idle_timeout observed_busy=%b expected=0", busy);
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL missing_pulse observed_pending=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic frame4(input logic [DW-1:0] a, b, c, d);
        samp(a); samp(b); samp(c); samp(d); idle(1);
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int placed;
        bit found;

        // Reset state
        #23;
        checks++;
        assert (sum_out === 32'h0 && sum_valid === 1'b0 && busy === 1'b0) else begin
            failures++;
            $error("FAIL reset_state observed=%h/%b/%b expected=0/0/0", sum_out, sum_valid, busy);
        end
        @(negedge clk); rst_n = 1'b1;

        // Basic frame, plus busy staying high through the pulse then falling
        set_all_w(16'h0800);
        frame4(16'h1000, 16'h1000, 16'h1000, 16'h1000);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (sum_valid === 1'b1) begin
                found = 1'b1;
                checks++;
                assert (busy === 1'b1 && sum_out === 32'h0200_0000) else begin
                    failures++;
                    $error("FAIL basic_pulse observed=%h busy=%b expected=02000000 busy=1", sum_out, busy);
                end
                @(negedge clk);
                checks++;
                assert (busy === 1'b0) else begin
                    failures++;
                    $error("FAIL busy_fall observed=%b expected=0", busy);
                end
            end
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL basic_no_pulse observed=none expected=pulse");
        end
        wait_idle();

        // Bias and mixed signs; last weight and bias written together
        wr(1'b1, 0, 16'h0800, 1'b0, '0, 1'b1);
        wr(1'b1, 1, 16'hF800, 1'b0, '0, 1'b1);
        wr(1'b1, 2, 16'h1000, 1'b0, '0, 1'b1);
        wr(1'b1, 3, 16'h0400, 1'b1, 32'h0000_0100, 1'b1);
        frame4(16'h0010, 16'h0010, 16'h0010, 16'h0020);
        wait_idle();

        // Positive and negative saturation
        wr(1'b0, 0, '0, 1'b1, 32'h0, 1'b1);
        set_all_w(16'h7FFF);
        frame4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        wait_idle();
        set_all_w(16'h8000);
        frame4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        wait_idle();

        // Back-to-back frames with every third cycle idle
        set_all_w(16'h0800);
        placed = 0;
        for (int c = 0; placed < 8; c++) begin
            if (c % 3 == 2) idle(1);
            else begin samp(DW'($urandom)); placed++; end
        end
        idle(1);
        wait_idle();

        // Write protection: ignored mid-frame, honoured when idle
        samp(16'h0100); samp(16'h0200);
        wr(1'b1, 0, 16'h7FFF, 1'b0, '0, 1'b0);
        samp(16'h0300); samp(16'h0400); idle(1);
        wait_idle();
        wr(1'b1, 0, 16'h7FFF, 1'b0, '0, 1'b1);
        frame4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        wait_idle();

        // Reset mid-frame: partial frame dropped, weights retained
        set_all_w(16'h0800);
        wr(1'b0, 0, '0, 1'b1, 32'h0000_0055, 1'b1);
        samp(16'h1000); samp(16'h1000); idle(1);
        rst_n = 1'b0;
        pos = 0;
        m_bias = 0;
        #2;
        checks++;
        assert (sum_out === 32'h0 && sum_valid === 1'b0 && busy === 1'b0) else begin
            failures++;
            $error("FAIL midframe_reset observed=%h/%b/%b expected=0/0/0", sum_out, sum_valid, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        frame4(16'h1000, 16'h1000, 16'h1000, 16'h1000);
        wait_idle();

        // Randomized frames: random weights, bias, data and gaps
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) wr(1'b1, i, DW'($urandom), 1'b0, '0, 1'b1);
            wr(1'b0, 0, '0, 1'b1, $urandom, 1'b1);
            for (int r = 0; r < 2; r++) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    samp(($urandom_range(0, 3) == 0) ? 16'h8000 : DW'($urandom));
                end
            end
            idle(1);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
